// File: rtl/hub75_pixel_fetch.sv
// Per-column framebuffer fetch for a HUB75 panel: reads the top and bottom half words
// from a 1-cycle-latency RAM and reduces each to one bit per colour for the active plane.
module hub75_pixel_fetch #(
  parameter int COL_BITS   = 6,
  parameter int ROW_BITS   = 4,
  parameter int DATA_WIDTH = 16,
  parameter int PLANE_BITS = 6
) (
  input  logic                         clk_in,
  input  logic                         reset,
  input  logic                         clk_pixel_load,
  input  logic [COL_BITS-1:0]          column_address,
  input  logic [ROW_BITS-1:0]          row_address,
  input  logic [PLANE_BITS-1:0]        brightness_mask,
  output logic [ROW_BITS+COL_BITS:0]   ram_addr,
  output logic                         ram_rd_en,
  input  logic [DATA_WIDTH-1:0]        ram_data,
  output logic [2:0]                   rgb1,
  output logic [2:0]                   rgb2,
  output logic                         rgb_valid,
  output logic                         busy,
  output logic                         overrun
);

  typedef enum logic [2:0] {IDLE, RD_TOP, RD_BOT, CAP_BOT, PRESENT} state_t;

  state_t                  state, next_state;
  logic [COL_BITS-1:0]     col_q, pend_col;
  logic [ROW_BITS-1:0]     row_q, pend_row;
  logic [PLANE_BITS-1:0]   mask_q, pend_mask;
  logic                    pend_q, half_q, overrun_q;
  logic [DATA_WIDTH-1:0]   top_q;
  logic [2:0]              rgb1_q, rgb2_q;
  logic                    fetching, take_new, take_pend;

  // RGB565 word -> {b,g,r} plane bits; 5-bit channels widen by replicating their MSB.
  function automatic logic [2:0] plane_bits(input logic [DATA_WIDTH-1:0] w,
                                            input logic [PLANE_BITS-1:0] m);
    logic [5:0] r6, g6, b6;
    r6 = {w[15:11], w[15]};
    g6 = w[10:5];
    b6 = {w[4:0], w[4]};
    return {|(b6 & m), |(g6 & m), |(r6 & m)};
  endfunction

  assign fetching  = (state == RD_TOP) || (state == RD_BOT) || (state == CAP_BOT);
  assign take_new  = clk_pixel_load && ((state == IDLE) || (state == PRESENT && !pend_q));
  assign take_pend = (state == PRESENT) && pend_q;

  always_ff @(posedge clk_in) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // NOTE: every signal assigned in a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (clk_pixel_load) next_state = RD_TOP;
      RD_TOP:  next_state = RD_BOT;
      RD_BOT:  next_state = CAP_BOT;
      CAP_BOT: next_state = PRESENT;
      PRESENT: next_state = (clk_pixel_load || pend_q) ? RD_TOP : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ram_rd_en = 1'b0;
    rgb_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      RD_TOP, RD_BOT: begin
        ram_rd_en = 1'b1;
        busy      = 1'b1;
      end
      CAP_BOT: busy = 1'b1;
      PRESENT: begin
        rgb_valid = 1'b1;
        busy      = clk_pixel_load || pend_q;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      col_q     <= '0;
      row_q     <= '0;
      mask_q    <= '0;
      pend_col  <= '0;
      pend_row  <= '0;
      pend_mask <= '0;
      pend_q    <= 1'b0;
      half_q    <= 1'b0;
      overrun_q <= 1'b0;
      top_q     <= '0;
      rgb1_q    <= '0;
      rgb2_q    <= '0;
    end else begin
      if (take_new) begin
        col_q  <= column_address;
        row_q  <= row_address;
        mask_q <= brightness_mask;
      end else if (take_pend) begin
        col_q  <= pend_col;
        row_q  <= pend_row;
        mask_q <= pend_mask;
      end

      // One-deep pending slot; a strobe arriving while it is full is lost.
      if (take_pend) begin
        pend_q <= 1'b0;
        if (clk_pixel_load) overrun_q <= 1'b1;
      end else if (fetching && clk_pixel_load) begin
        if (!pend_q) begin
          pend_q    <= 1'b1;
          pend_col  <= column_address;
          pend_row  <= row_address;
          pend_mask <= brightness_mask;
        end else begin
          overrun_q <= 1'b1;
        end
      end

      if (next_state == RD_TOP)      half_q <= 1'b0;
      else if (next_state == RD_BOT) half_q <= 1'b1;

      if (state == RD_BOT) top_q <= ram_data;
      if (state == CAP_BOT) begin
        rgb1_q <= plane_bits(top_q, mask_q);
        rgb2_q <= plane_bits(ram_data, mask_q);
      end
    end
  end

  // Address is built from registers only, so it holds between fetches.
  assign ram_addr = {half_q, row_q, col_q};
  assign rgb1     = rgb1_q;
  assign rgb2     = rgb2_q;
  assign overrun  = overrun_q;

endmodule
